// File: rtl/pattern_ctrl_if.sv
// Signal bundle between the pattern scheduler and its surroundings.
// The master side drives blanking and buttons; the slave side (the scheduler) returns pattern state.
interface pattern_ctrl_if;
  logic        VBlank;
  logic        btn_next;
  logic        btn_prev;
  logic        btn_auto;
  logic [3:0]  pattern;
  logic        pattern_strobe;
  logic        auto_mode;
  logic        osd_active;
  logic [15:0] frame_cnt;

  modport master (
    output VBlank, btn_next, btn_prev, btn_auto,
    input  pattern, pattern_strobe, auto_mode, osd_active, frame_cnt
  );

  modport slave (
    input  VBlank, btn_next, btn_prev, btn_auto,
    output pattern, pattern_strobe, auto_mode, osd_active, frame_cnt
  );
endinterface

// File: rtl/pattern_ctrl.sv
// Frame-synchronous test-pattern scheduler: button requests and slideshow advances are
// committed only at the start of vertical blank, plus OSD banner timer and frame counter.
module pattern_ctrl #(
  parameter int NUM_PAT     = 12,
  parameter int AUTO_FRAMES = 300,
  parameter int OSD_FRAMES  = 120
) (
  input  logic          clk,
  input  logic          reset,
  pattern_ctrl_if.slave bus
);

  localparam logic [0:0]  MANUAL    = 1'b0;
  localparam logic [0:0]  AUTO      = 1'b1;
  localparam logic [3:0]  PAT_LAST  = 4'(NUM_PAT - 1);
  localparam logic [15:0] AUTO_LAST = 16'(AUTO_FRAMES - 1);
  localparam logic [7:0]  OSD_LOAD  = 8'(OSD_FRAMES);

  logic        vb_q, next_q, prev_q, auto_q;
  logic        req_next_reg, req_prev_reg, req_auto_reg;
  logic        req_next_next, req_prev_next, req_auto_next;
  logic [0:0]  state_reg, state_next;
  logic [15:0] auto_cnt_reg, auto_cnt_next;
  logic [7:0]  osd_cnt_reg, osd_cnt_next;
  logic [3:0]  pattern_reg, pattern_next;
  logic        strobe_reg, strobe_next;
  logic [15:0] frame_cnt_reg, frame_cnt_next;

  logic fb, press_next, press_prev, press_auto;
  logic step_up, step_dn, auto_fire, changed;
  logic [3:0] pat_inc, pat_dec;

  assign fb         = bus.VBlank & ~vb_q;
  assign press_next = bus.btn_next & ~next_q;
  assign press_prev = bus.btn_prev & ~prev_q;
  assign press_auto = bus.btn_auto & ~auto_q;

  assign step_up   = req_next_reg & ~req_prev_reg;
  assign step_dn   = req_prev_reg & ~req_next_reg;
  // Slideshow advance yields to manual steps and to a pending mode toggle.
  assign auto_fire = (state_reg == AUTO) & ~req_auto_reg & ~step_up & ~step_dn
                     & (auto_cnt_reg == AUTO_LAST);
  assign changed   = step_up | step_dn | auto_fire;

  assign pat_inc = (pattern_reg == PAT_LAST) ? 4'd0 : pattern_reg + 4'd1;
  assign pat_dec = (pattern_reg == 4'd0) ? PAT_LAST : pattern_reg - 4'd1;

  always_comb begin
    req_next_next  = req_next_reg | press_next;
    req_prev_next  = req_prev_reg | press_prev;
    req_auto_next  = req_auto_reg | press_auto;
    state_next     = state_reg;
    auto_cnt_next  = auto_cnt_reg;
    osd_cnt_next   = osd_cnt_reg;
    pattern_next   = pattern_reg;
    strobe_next    = 1'b0;
    frame_cnt_next = frame_cnt_reg;

    if (fb) begin
      // A press landing on the FB cycle itself survives into the next frame.
      req_next_next  = press_next;
      req_prev_next  = press_prev;
      req_auto_next  = press_auto;
      frame_cnt_next = frame_cnt_reg + 16'd1;

      if (step_up || auto_fire)
        pattern_next = pat_inc;
      else if (step_dn)
        pattern_next = pat_dec;
      strobe_next = changed;

      if (req_auto_reg) begin
        state_next    = (state_reg == MANUAL) ? AUTO : MANUAL;
        auto_cnt_next = 16'd0;
      end else if (state_reg == AUTO) begin
        auto_cnt_next = changed ? 16'd0 : auto_cnt_reg + 16'd1;
      end

      if (changed || req_auto_reg)
        osd_cnt_next = OSD_LOAD;
      else if (osd_cnt_reg != 8'd0)
        osd_cnt_next = osd_cnt_reg - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Treat blanking and buttons as already high so nothing held through reset fires.
      vb_q          <= 1'b1;
      next_q        <= 1'b1;
      prev_q        <= 1'b1;
      auto_q        <= 1'b1;
      req_next_reg  <= 1'b0;
      req_prev_reg  <= 1'b0;
      req_auto_reg  <= 1'b0;
      state_reg     <= MANUAL;
      auto_cnt_reg  <= 16'd0;
      osd_cnt_reg   <= 8'd0;
      pattern_reg   <= 4'd0;
      strobe_reg    <= 1'b0;
      frame_cnt_reg <= 16'd0;
    end else begin
      vb_q          <= bus.VBlank;
      next_q        <= bus.btn_next;
      prev_q        <= bus.btn_prev;
      auto_q        <= bus.btn_auto;
      req_next_reg  <= req_next_next;
      req_prev_reg  <= req_prev_next;
      req_auto_reg  <= req_auto_next;
      state_reg     <= state_next;
      auto_cnt_reg  <= auto_cnt_next;
      osd_cnt_reg   <= osd_cnt_next;
      pattern_reg   <= pattern_next;
      strobe_reg    <= strobe_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  assign bus.pattern        = pattern_reg;
  assign bus.pattern_strobe = strobe_reg;
  assign bus.auto_mode      = (state_reg == AUTO);
  assign bus.osd_active     = (osd_cnt_reg != 8'd0);
  assign bus.frame_cnt      = frame_cnt_reg;

endmodule

// File: doc/pattern_ctrl.md
# pattern_ctrl

Frame-synchronous test-pattern scheduler for the 240p suite. Takes button presses from the joystick/OSD path and the blanking outputs of the video timing generator. Decides which pattern the generator draws, committing every change only at the start of vertical blank, so a visible frame never mixes two patterns. Also provides an auto-advance (slideshow) mode, a per-change OSD banner timer and a free-running frame counter.

## Interface
- NUM_PAT, 12, number of patterns; pattern IDs 0..NUM_PAT-1; legal range 2..16
- AUTO_FRAMES, 300, frames per pattern in auto mode; legal range 1..65535
- OSD_FRAMES, 120, frames the banner stays up after a change; legal range 1..255
- clk  in  1  system clock (same domain as the timing generator)
- reset  in  1  synchronous, active-high
- VBlank  in  1  vertical blank from the timing generator, synchronous to clk
- btn_next  in  1  level, synchronous to clk; rising edge = advance request
- btn_prev  in  1  level, synchronous to clk; rising edge = go-back request
- btn_auto  in  1  level, synchronous to clk; rising edge = toggle auto mode
- pattern  out  4  current pattern ID
- pattern_strobe  out  1  one-clk pulse on the cycle `pattern` takes a new value
- auto_mode  out  1  1 = AUTO state
- osd_active  out  1  banner enable
- frame_cnt  out  16  frames since reset, wraps 65535->0

## Operation
- Edge detection:
  - vb_q, next_q, prev_q and auto_q are registered copies of their inputs.
  - Frame boundary (FB) = VBlank & ~vb_q.
  - A press = btn & ~btn_q.
- Request latches: req_next, req_prev and req_auto are set by a press and cleared at FB.
  - Repeated presses within one frame collapse to one request.
  - A press on the FB cycle itself is not applied at that FB; it is held for the next FB.
- At FB, net step = req_next - req_prev:
  - +1: pattern = (pattern == NUM_PAT-1) ? 0 : pattern+1.
  - -1: pattern = (pattern == 0) ? NUM_PAT-1 : pattern-1.
  - 0 (neither or both requested): no change.
- FSM states: MANUAL (reset state) and AUTO.
  - MANUAL -> AUTO when req_auto is set at FB.
  - AUTO -> MANUAL when req_auto is set at FB.
  - On entering AUTO, auto_cnt = 0.
- In AUTO, auto_cnt counts FBs.
  - At an FB where auto_cnt == AUTO_FRAMES-1 and the net manual step is 0: advance +1 (with wrap) and set auto_cnt = 0.
  - Any nonzero manual step at FB wins over auto-advance and sets auto_cnt = 0.
- OSD: osd_cnt (8 bit) is loaded with OSD_FRAMES at an FB where pattern changes or the state toggles; otherwise it decrements at FB while nonzero. osd_active = (osd_cnt != 0).
- frame_cnt increments at every FB.

## Timing
- Reset values:
  - pattern = 0, pattern_strobe = 0, auto_mode = 0, osd_active = 0, frame_cnt = 0.
  - All request latches 0, auto_cnt = 0, osd_cnt = 0, FSM = MANUAL.
  - vb_q = 1, so reset asserted mid-VBlank produces no FB until VBlank falls and rises again.
  - btn_q = 1, so a button held through reset is not a press.
- All FB effects land on the clock edge at the end of the FB cycle, i.e. 1 clk after VBlank is first sampled high:
  - pattern, pattern_strobe, auto_mode, osd_active and frame_cnt update on that same edge.
  - pattern_strobe is high for exactly that one cycle, and only if the value changed.
- Press-to-commit latency: the first FB after the press cycle; worst case one full frame (256 lines x 400 pixel clocks at the generator's rate).
- Request latches set on the edge following the press cycle.
- Reset mid-frame discards pending requests. Reset takes priority over FB on the same cycle.
- AUTO_FRAMES = 1 advances at every FB.

## Test plan
- Reset, then 3 frames with no buttons -> pattern = 0, no strobe, frame_cnt = 3, osd_active = 0.
- Pulse btn_next mid-frame 3 times in one frame -> at next FB pattern 0->1, exactly one strobe 1 clk after VBlank rise, osd_active high for 120 frames then low.
- From pattern 0, press btn_prev -> pattern 11. From pattern 11, press btn_next -> 0. btn_next and btn_prev in the same frame -> no change, no strobe, osd not reloaded.
- Press btn_next on the exact FB cycle -> no change at that FB; change to +1 at the following FB.
- AUTO_FRAMES = 4: press btn_auto -> auto_mode = 1 at next FB, then pattern advances every 4th FB. A btn_next in frame 2 advances at that FB and restarts the 4-frame count.
- Hold btn_next high across reset, assert reset during VBlank -> no FB, no press detected, pattern stays 0.
